// File: rtl/regfile_wb_scheduler.sv
// Owns the register-file write port: pipeline WB beats the long unit, zero-latency arbitration.
// Long-unit results wait via lu_ready; ID stalls on RAW/WAW/capacity hazards and on write-port starvation.
module regfile_wb_scheduler #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8,
    parameter int CNT_W           = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1Addr,
    input  logic [4:0]       id_rs2Addr,
    input  logic [4:0]       id_rdAddr,
    input  logic             id_rdWrite,
    input  logic             id_isLong,
    output logic             stall,
    input  logic             wb_valid,
    input  logic [4:0]       wb_addr,
    input  logic [31:0]      wb_data,
    input  logic             lu_valid,
    input  logic [4:0]       lu_addr,
    input  logic [31:0]      lu_data,
    output logic             lu_ready,
    output logic             RegWrite,
    output logic [4:0]       WriteAddr,
    output logic [31:0]      WriteData,
    output logic [31:0]      pending,
    output logic [CNT_W-1:0] outstanding
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] OUT_MAX    = CNT_W'(MAX_OUTSTANDING);

    logic [SW-1:0] starve_cnt;
    logic          wb_busy;
    logic          transfer;
    logic          starve_stall;
    logic          raw_hazard;
    logic          waw_hazard;
    logic          cap_hazard;
    logic          issue;
    logic [31:0]   set_mask;
    logic [31:0]   clr_mask;

    assign wb_busy = wb_valid && (wb_addr != 5'd0);

    // WB to x0 is a no-op write, so it must not cost the long unit its slot.
    always_comb begin
        RegWrite  = 1'b0;
        WriteAddr = 5'd0;
        WriteData = 32'd0;
        lu_ready  = 1'b0;
        if (!rst) begin
            if (wb_busy) begin
                RegWrite  = 1'b1;
                WriteAddr = wb_addr;
                WriteData = wb_data;
            end else if (lu_valid) begin
                lu_ready  = 1'b1;
                RegWrite  = (lu_addr != 5'd0);
                WriteAddr = lu_addr;
                WriteData = lu_data;
            end
        end
    end

    assign transfer     = lu_valid && lu_ready;
    assign starve_stall = (starve_cnt == STARVE_MAX);

    // Hazards use pre-edge pending, so a register completing this cycle still stalls once.
    assign raw_hazard = ((id_rs1Addr != 5'd0) && pending[id_rs1Addr])
                     || ((id_rs2Addr != 5'd0) && pending[id_rs2Addr]);
    assign waw_hazard = id_rdWrite && (id_rdAddr != 5'd0) && pending[id_rdAddr];
    assign cap_hazard = id_isLong && (outstanding == OUT_MAX);

    assign stall = rst || starve_stall
                || (id_valid && (raw_hazard || waw_hazard || cap_hazard));

    assign issue    = id_valid && !stall && id_isLong;
    assign set_mask = (issue && id_rdWrite && (id_rdAddr != 5'd0)) ? (32'd1 << id_rdAddr) : 32'd0;
    assign clr_mask = transfer ? (32'd1 << lu_addr) : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= 32'd0;
            outstanding <= '0;
            starve_cnt  <= '0;
        end else begin
            pending <= ((pending & ~clr_mask) | set_mask) & ~32'd1;

            if (issue && !transfer)
                outstanding <= outstanding + 1'b1;
            else if (transfer && !issue)
                outstanding <= outstanding - 1'b1;

            if (!lu_valid || transfer)
                starve_cnt <= '0;
            else if (starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    a_no_transfer_when_empty : assert property (
        @(posedge clk) disable iff (rst) !(transfer && (outstanding == '0)));

    a_no_issue_over_capacity : assert property (
        @(posedge clk) disable iff (rst) !(issue && (outstanding == OUT_MAX)));

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios plus a write-port scoreboard.
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1Addr, id_rs2Addr, id_rdAddr;
    logic        id_rdWrite, id_isLong;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        RegWrite;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;
    logic [31:0] pending;
    logic [2:0]  outstanding;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] regs[32];
    int          vectors     = 0;
    int          miscompares = 0;

    regfile_wb_scheduler #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(8), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1Addr(id_rs1Addr), .id_rs2Addr(id_rs2Addr),
        .id_rdAddr(id_rdAddr), .id_rdWrite(id_rdWrite), .id_isLong(id_isLong),
        .stall(stall),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data), .lu_ready(lu_ready),
        .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData),
        .pending(pending), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    // Register-file model built from the write port, used to confirm committed values.
    always @(posedge clk) begin
        if (!rst && RegWrite) regs[WriteAddr] = WriteData;
    end

    // Scoreboard: every register-file write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && RegWrite) begin
            wr_t e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL write_unexpected: got addr=%0d data=%h, required no write", WriteAddr, WriteData);
            end else begin
                e = exp_q.pop_front();
                if (WriteAddr !== e.addr || WriteData !== e.data) begin
                    miscompares++;
                    $display("FAIL write_port: got addr=%0d data=%h, required addr=%0d data=%h",
                             WriteAddr, WriteData, e.addr, e.data);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs1Addr = 0; id_rs2Addr = 0; id_rdAddr = 0;
        id_rdWrite = 0; id_isLong = 0;
        wb_valid = 0; wb_addr = 0; wb_data = 0;
        lu_valid = 0; lu_addr = 0; lu_data = 0;
    endtask

    task automatic drive_long(input logic [4:0] rd);
        id_valid = 1; id_isLong = 1; id_rdWrite = 1; id_rdAddr = rd;
        id_rs1Addr = 0; id_rs2Addr = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        idle_inputs();
        rst = 1;
        lu_valid = 1; lu_addr = 5'd3; lu_data = 32'h33;
        wb_valid = 1; wb_addr = 5'd2; wb_data = 32'h22;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++;
            if (stall !== 1'b1 || RegWrite !== 1'b0 || lu_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_outputs: got stall=%b RegWrite=%b lu_ready=%b, required 1 0 0",
                         stall, RegWrite, lu_ready);
            end
            next_cycle();
        end
        rst = 0;
        idle_inputs();
        @(negedge clk);
        vectors++;
        if (pending !== 32'd0 || outstanding !== 3'd0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got pending=%h outstanding=%0d stall=%b, required 0 0 0",
                     pending, outstanding, stall);
        end
    endtask

    task automatic test_raw();
        next_cycle();
        drive_long(5'd5);
        @(negedge clk);
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL raw_issue_stall: got %b, required 0", stall);
        end
        next_cycle();
        idle_inputs();
        id_valid = 1; id_rs1Addr = 5'd5; id_rdWrite = 1; id_rdAddr = 5'd6;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++;
            if (pending !== 32'h20 || outstanding !== 3'd1 || stall !== 1'b1) begin
                miscompares++;
                $display("FAIL raw_wait: got pending=%h outstanding=%0d stall=%b, required 20 1 1",
                         pending, outstanding, stall);
            end
            next_cycle();
        end
        lu_valid = 1; lu_addr = 5'd5; lu_data = 32'h1234;
        exp_q.push_back('{addr: 5'd5, data: 32'h1234});
        @(negedge clk);
        vectors++;
        if (stall !== 1'b1 || lu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL raw_same_cycle: got stall=%b lu_ready=%b, required 1 1", stall, lu_ready);
        end
        next_cycle();
        lu_valid = 0;
        @(negedge clk);
        vectors++;
        if (pending !== 32'd0 || stall !== 1'b0 || outstanding !== 3'd0 || regs[5] !== 32'h1234) begin
            miscompares++;
            $display("FAIL raw_release: got pending=%h stall=%b outstanding=%0d x5=%h, required 0 0 0 1234",
                     pending, stall, outstanding, regs[5]);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_conflict();
        drive_long(5'd7);
        next_cycle();
        idle_inputs();
        wb_valid = 1; wb_addr = 5'd3; wb_data = 32'hA;
        lu_valid = 1; lu_addr = 5'd7; lu_data = 32'h77;
        exp_q.push_back('{addr: 5'd3, data: 32'hA});
        @(negedge clk);
        vectors++;
        if (WriteAddr !== 5'd3 || lu_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL conflict_wb_wins: got WriteAddr=%0d lu_ready=%b, required 3 0", WriteAddr, lu_ready);
        end
        next_cycle();
        wb_valid = 0;
        exp_q.push_back('{addr: 5'd7, data: 32'h77});
        @(negedge clk);
        vectors++;
        if (WriteAddr !== 5'd7 || lu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL conflict_lu_next: got WriteAddr=%0d lu_ready=%b, required 7 1", WriteAddr, lu_ready);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        vectors++;
        if (outstanding !== 3'd0 || pending !== 32'd0 || regs[3] !== 32'hA || regs[7] !== 32'h77) begin
            miscompares++;
            $display("FAIL conflict_end: got outstanding=%0d pending=%h x3=%h x7=%h, required 0 0 a 77",
                     outstanding, pending, regs[3], regs[7]);
        end
    endtask

    task automatic test_starvation();
        next_cycle();
        drive_long(5'd10);
        next_cycle();
        idle_inputs();
        lu_valid = 1; lu_addr = 5'd10; lu_data = 32'hCAFE;
        wb_valid = 1; wb_addr = 5'd4;
        for (int w = 1; w <= 9; w++) begin
            wb_data = 32'h400 + w;
            exp_q.push_back('{addr: 5'd4, data: 32'h400 + w});
            @(negedge clk);
            vectors++;
            if (stall !== (w == 9) || lu_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL starve_wait%0d: got stall=%b lu_ready=%b, required %b 0",
                         w, stall, lu_ready, (w == 9));
            end
            next_cycle();
        end
        wb_valid = 0;
        exp_q.push_back('{addr: 5'd10, data: 32'hCAFE});
        @(negedge clk);
        vectors++;
        if (stall !== 1'b1 || lu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL starve_transfer: got stall=%b lu_ready=%b, required 1 1", stall, lu_ready);
        end
        next_cycle();
        lu_valid = 0;
        @(negedge clk);
        vectors++;
        if (stall !== 1'b0 || outstanding !== 3'd0) begin
            miscompares++;
            $display("FAIL starve_release: got stall=%b outstanding=%0d, required 0 0", stall, outstanding);
        end
    endtask

    task automatic test_capacity();
        logic [4:0] rds[4] = '{5'd1, 5'd2, 5'd3, 5'd0};
        logic [4:0] drain[4] = '{5'd1, 5'd2, 5'd3, 5'd8};
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive_long(rds[i]);
            @(negedge clk);
            vectors++;
            if (stall !== 1'b0) begin
                miscompares++;
                $display("FAIL cap_issue%0d: got stall=%b, required 0", i, stall);
            end
        end
        next_cycle();
        drive_long(5'd8);
        @(negedge clk);
        vectors++;
        if (outstanding !== 3'd4 || pending !== 32'h0E || stall !== 1'b1) begin
            miscompares++;
            $display("FAIL cap_full: got outstanding=%0d pending=%h stall=%b, required 4 e 1",
                     outstanding, pending, stall);
        end
        next_cycle();
        lu_valid = 1; lu_addr = 5'd0; lu_data = 32'h55;
        @(negedge clk);
        vectors++;
        if (RegWrite !== 1'b0 || lu_ready !== 1'b1 || stall !== 1'b1) begin
            miscompares++;
            $display("FAIL cap_x0_complete: got RegWrite=%b lu_ready=%b stall=%b, required 0 1 1",
                     RegWrite, lu_ready, stall);
        end
        next_cycle();
        lu_valid = 0;
        @(negedge clk);
        vectors++;
        if (outstanding !== 3'd3 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL cap_proceed: got outstanding=%0d stall=%b, required 3 0", outstanding, stall);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        vectors++;
        if (outstanding !== 3'd4 || pending !== 32'h10E) begin
            miscompares++;
            $display("FAIL cap_reissued: got outstanding=%0d pending=%h, required 4 10e", outstanding, pending);
        end
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            lu_valid = 1; lu_addr = drain[i]; lu_data = 32'hD000 + i;
            exp_q.push_back('{addr: drain[i], data: 32'hD000 + i});
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        vectors++;
        if (outstanding !== 3'd0 || pending !== 32'd0) begin
            miscompares++;
            $display("FAIL cap_drained: got outstanding=%0d pending=%h, required 0 0", outstanding, pending);
        end
    endtask

    task automatic test_waw_x0();
        next_cycle();
        drive_long(5'd9);
        next_cycle();
        idle_inputs();
        id_valid = 1; id_rdWrite = 1; id_rdAddr = 5'd9;
        @(negedge clk);
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL waw_stall: got %b, required 1", stall);
        end
        next_cycle();
        id_rdAddr = 5'd11;
        @(negedge clk);
        vectors++;
        if (stall !== 1'b0 || pending !== 32'h200) begin
            miscompares++;
            $display("FAIL x0_sources: got stall=%b pending=%h, required 0 200", stall, pending);
        end
        next_cycle();
        drive_long(5'd12);
        lu_valid = 1; lu_addr = 5'd9; lu_data = 32'h9999;
        exp_q.push_back('{addr: 5'd9, data: 32'h9999});
        @(negedge clk);
        vectors++;
        if (stall !== 1'b0 || lu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL issue_and_complete: got stall=%b lu_ready=%b, required 0 1", stall, lu_ready);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        vectors++;
        if (outstanding !== 3'd1 || pending !== 32'h1000) begin
            miscompares++;
            $display("FAIL issue_and_complete_state: got outstanding=%0d pending=%h, required 1 1000",
                     outstanding, pending);
        end
        next_cycle();
        wb_valid = 1; wb_addr = 5'd0; wb_data = 32'hDEAD;
        lu_valid = 1; lu_addr = 5'd12; lu_data = 32'hC0C0;
        exp_q.push_back('{addr: 5'd12, data: 32'hC0C0});
        @(negedge clk);
        vectors++;
        if (lu_ready !== 1'b1 || WriteAddr !== 5'd12) begin
            miscompares++;
            $display("FAIL wb_x0_no_block: got lu_ready=%b WriteAddr=%0d, required 1 12", lu_ready, WriteAddr);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        vectors++;
        if (outstanding !== 3'd0 || pending !== 32'd0 || regs[0] !== 32'd0) begin
            miscompares++;
            $display("FAIL waw_end: got outstanding=%0d pending=%h x0=%h, required 0 0 0",
                     outstanding, pending, regs[0]);
        end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_conflict();
        test_starvation();
        test_capacity();
        test_waw_x0();
        next_cycle();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d writes still expected, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Owns the single write port of the 32x32 register file (write-through bypass, x0 hard-wired zero).
- Arbitrates that port between the in-order pipeline WB stage and a multi-cycle long-latency unit (mul/div/load-miss).
- Keeps a per-register pending scoreboard for long-unit destinations and generates the ID-stage stall for RAW/WAW hazards, outstanding-limit and write-port starvation.

Parameters:
MAX_OUTSTANDING, 4, max long ops in flight (1..7)
STARVE_LIMIT, 8, cycles a long-unit result may wait before ID is stalled to create WB bubbles (>=1)
CNT_W, 3, width of outstanding counter, must hold MAX_OUTSTANDING

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  instruction present in ID
id_rs1Addr  in  5  ID source 1
id_rs2Addr  in  5  ID source 2
id_rdAddr  in  5  ID destination
id_rdWrite  in  1  ID instruction writes rd
id_isLong  in  1  ID instruction issues to long unit
stall  out  1  hold IF/ID, inject bubble into EX
wb_valid  in  1  pipeline WB write request (never stallable)
wb_addr  in  5  pipeline WB destination
wb_data  in  32  pipeline WB data
lu_valid  in  1  long unit has a result
lu_addr  in  5  long-unit destination
lu_data  in  32  long-unit data
lu_ready  out  1  long-unit result accepted this cycle
RegWrite  out  1  to register file
WriteAddr  out  5  to register file
WriteData  out  32  to register file
pending  out  32  scoreboard vector (debug/verification)
outstanding  out  CNT_W  long ops in flight

Behaviour:
- State: pending[31:0], outstanding, starve_cnt.
- Reset (rst high at edge) clears all three to 0.
- While rst high, combinationally: stall=1, lu_ready=0, RegWrite=0.
- pending[0] is never set.
- Write-port arbitration (combinational, zero latency):
  - wb_busy = wb_valid && wb_addr!=0.
  - wb_busy -> RegWrite=1, WriteAddr=wb_addr, WriteData=wb_data, lu_ready=0.
  - else lu_valid -> lu_ready=1, WriteAddr=lu_addr, WriteData=lu_data, RegWrite=(lu_addr!=0).
  - else RegWrite=0, WriteAddr=0, WriteData=0.
  - Pipeline WB always has priority: WB writes to x0 do not block the long unit.
- Long-unit handshake:
  - lu_valid, lu_addr and lu_data are held stable until lu_ready=1.
  - Transfer occurs on the cycle lu_valid && lu_ready.
- Starvation:
  - starve_cnt increments each cycle lu_valid && !lu_ready, saturating at STARVE_LIMIT.
  - It clears to 0 on transfer or when !lu_valid.
  - starve_stall = (starve_cnt == STARVE_LIMIT); it remains asserted until transfer.
- Hazard stall is combinational from ID inputs and registered state, asserted only when id_valid:
  - RAW: rs1!=0 && pending[rs1], or rs2!=0 && pending[rs2].
  - WAW: id_rdWrite && rd!=0 && pending[rd].
  - Capacity: id_isLong && outstanding==MAX_OUTSTANDING.
  - stall = rst || starve_stall || (id_valid && (RAW || WAW || capacity)).
  - starve_stall stalls even when id_valid=0.
- Issue: id_valid && !stall && id_isLong sets pending[rd] next edge if rd!=0 and id_rdWrite, and increments outstanding. A long op with rd=0 still counts.
- Completion: transfer clears pending[lu_addr] next edge and decrements outstanding.
- Simultaneous issue and completion in the same cycle: outstanding unchanged, set and clear applied to their respective bits.
- Same-bit set and clear in one cycle cannot occur: WAW stall blocks issue to a pending rd, because the stall is computed from the pre-edge pending.
- Same-cycle bypass: a RAW on the register being completed this cycle still stalls one cycle. No forwarding from lu_data to ID; the register file write-through covers the following cycle.
- Assertions:
  - Transfer with outstanding==0 is illegal.
  - Issue at outstanding==MAX_OUTSTANDING without stall cannot happen.

Test Plan:
- Reset: hold rst 2 cycles with lu_valid=1, wb_valid=1 -> stall=1, RegWrite=0, lu_ready=0. After release: pending=0, outstanding=0.
- Long issue rd=5, then ID reads rs1=5 -> pending=0x20, stall=1 until lu_valid(addr 5, data 0x1234) transfers. Next cycle pending=0, stall=0; register file x5=0x1234.
- Port conflict: wb_valid(addr 3, data 0xA) and lu_valid(addr 7) same cycle -> WriteAddr=3, lu_ready=0. Next cycle with wb_valid=0 -> WriteAddr=7, lu_ready=1.
- Starvation, STARVE_LIMIT=8: wb_valid=1 (addr 4) continuously, lu_valid held -> stall rises on the 9th waiting cycle. Drop wb_valid -> transfer, stall falls the next cycle.
- Capacity: issue 4 long ops (rd 1,2,3,0) -> outstanding=4, pending=0x0E. 5th long issue stalls; completion of rd 0 with RegWrite=0 -> outstanding=3, issue proceeds.
- WAW and x0: long op pending on rd=9, ALU op with rd=9 -> stall. ID rs1=0, rs2=0 with pending nonzero -> no stall. Issue and completion same cycle -> outstanding unchanged.
